// File: rtl/mem_arb_pkg.sv
// mem_arb_pkg: shared state encoding, size defaults and port indices for the program RAM arbiter
package mem_arb_pkg;
    typedef enum logic [2:0] {S_IDLE, S_LATCH, S_RD, S_WSETUP, S_WR, S_WHOLD, S_ACK} state_t;
    localparam int AW_DEF = 4;
    localparam int DW_DEF = 8;
    localparam logic PORT_C = 1'b0;
    localparam logic PORT_P = 1'b1;
endpackage

// File: rtl/mem_arb_rr.sv
// mem_arb_rr: two-input winner select with a registered last-grant pointer
module mem_arb_rr import mem_arb_pkg::*; #(
    parameter int P_PRIO = 0
) (
    input  logic CLK,
    input  logic nRST,
    input  logic c_req,
    input  logic p_req,
    input  logic grant,
    output logic win
);
    logic last;
    // on a tie the port not granted last time wins, unless P has fixed priority
    assign win = (c_req && p_req) ? ((P_PRIO != 0) ? PORT_P : ~last) : (p_req ? PORT_P : PORT_C);
    always_ff @(posedge CLK or negedge nRST)
        if (!nRST) last <= PORT_P;
        else if (grant) last <= win;
endmodule

// File: rtl/mem_arbiter.sv
// mem_arbiter: two-port arbiter and strobe sequencer for the 16 x 8 program RAM
module mem_arbiter import mem_arb_pkg::*; #(
    parameter int AW     = AW_DEF,
    parameter int DW     = DW_DEF,
    parameter int P_PRIO = 0
) (
    input  logic          CLK,
    input  logic          nRST,
    input  logic          C_REQ,
    input  logic          C_WE,
    input  logic [AW-1:0] C_ADDR,
    input  logic [DW-1:0] C_WDATA,
    input  logic          P_REQ,
    input  logic          P_WE,
    input  logic [AW-1:0] P_ADDR,
    input  logic [DW-1:0] P_WDATA,
    output logic          C_GNT,
    output logic          P_GNT,
    output logic          C_DONE,
    output logic          P_DONE,
    output logic [DW-1:0] RDATA,
    output logic          BUSY,
    output logic          nLm,
    output logic          nCE,
    output logic          nWE,
    output logic [AW-1:0] ABUS,
    output logic [DW-1:0] DOUT,
    output logic          DOE,
    input  logic [DW-1:0] DIN
);
    state_t state, nxt;
    logic   win, win_we, any_req, grant;

    assign any_req = C_REQ | P_REQ;
    assign grant   = (state == S_IDLE) && any_req;
    assign win_we  = (win == PORT_P) ? P_WE : C_WE;

    mem_arb_rr #(.P_PRIO(P_PRIO)) u_rr (
        .CLK   (CLK),
        .nRST  (nRST),
        .c_req (C_REQ),
        .p_req (P_REQ),
        .grant (grant),
        .win   (win)
    );

    always_ff @(posedge CLK or negedge nRST)
        if (!nRST) state <= S_IDLE;
        else state <= nxt;

    always_comb begin
        nxt = state;
        case (state)
            S_IDLE:   nxt = any_req ? (win_we ? S_WSETUP : S_LATCH) : S_IDLE;
            S_LATCH:  nxt = S_RD;
            S_RD:     nxt = S_ACK;
            S_WSETUP: nxt = S_WR;
            S_WR:     nxt = S_WHOLD;
            S_WHOLD:  nxt = S_ACK;
            default:  nxt = S_IDLE;
        endcase
    end

    // every output is decoded from the next state and registered, keeping strobes glitch-free
    always_ff @(posedge CLK or negedge nRST)
        if (!nRST) begin
            nLm    <= 1'b1;
            nCE    <= 1'b1;
            nWE    <= 1'b1;
            DOE    <= 1'b0;
            BUSY   <= 1'b0;
            C_DONE <= 1'b0;
            P_DONE <= 1'b0;
            C_GNT  <= 1'b0;
            P_GNT  <= 1'b0;
            ABUS   <= '0;
            DOUT   <= '0;
            RDATA  <= '0;
        end else begin
            nLm    <= nxt != S_LATCH;
            nCE    <= nxt != S_RD;
            nWE    <= nxt != S_WR;
            DOE    <= nxt inside {S_WSETUP, S_WR, S_WHOLD};
            BUSY   <= nxt != S_IDLE;
            C_DONE <= (nxt == S_ACK) && C_GNT;
            P_DONE <= (nxt == S_ACK) && P_GNT;
            if (grant) begin
                C_GNT <= win == PORT_C;
                P_GNT <= win == PORT_P;
                ABUS  <= (win == PORT_P) ? P_ADDR : C_ADDR;
                DOUT  <= (win == PORT_P) ? P_WDATA : C_WDATA;
            end else if (state == S_ACK) begin
                C_GNT <= 1'b0;
                P_GNT <= 1'b0;
            end
            if (state == S_RD) RDATA <= DIN;
        end
endmodule

// File: doc/mem_arbiter.md
# mem_arbiter

Two-port arbiter and access sequencer for the 16 x 8 program RAM. It shares the RAM between two requesters:
- the CPU control sequencer (port C);
- the front-panel/serial program loader (port P).

It generates the RAM's active-low strobes (nLm, nCE, nWE), the address bus, and write data with a drive-enable. Reads and writes run as fixed multi-cycle sequences, so requesters only see a simple req/done handshake.

## Interface
- AW, 4, address width (RAM depth 1<<AW)
- DW, 8, data width
- P_PRIO, 0, 0 = round-robin between C and P; 1 = P always wins a tie
- CLK  in  1  system clock, rising edge
- nRST  in  1  asynchronous, active-low reset
- C_REQ / P_REQ  in  1  access request, held until matching DONE
- C_WE / P_WE  in  1  1 = write, 0 = read; valid with REQ
- C_ADDR / P_ADDR  in  AW  access address; valid with REQ
- C_WDATA / P_WDATA  in  DW  write data; valid with REQ
- C_GNT / P_GNT  out  1  high from grant until end of ACK state
- C_DONE / P_DONE  out  1  one-cycle completion pulse
- RDATA  out  DW  read result; valid while either DONE is high, holds until next read
- BUSY  out  1  high in any state other than IDLE
- nLm  out  1  RAM address-latch strobe, active low
- nCE  out  1  RAM output enable, active low
- nWE  out  1  RAM write enable, active low
- ABUS  out  AW  RAM address
- DOUT  out  DW  data to drive onto the RAM data bus
- DOE  out  1  1 = top level drives DOUT onto the bus (tri-state is outside this block)
- DIN  in  DW  RAM data bus as read back

## Operation
- States: IDLE, LATCH, RD, WSETUP, WR, WHOLD, ACK. All outputs are registered, so strobes are glitch-free.
- IDLE, neither REQ high: stay in IDLE.
- IDLE, any REQ high, at the clock edge:
  - choose a winner;
  - set its GNT;
  - capture its WE, ADDR and WDATA into internal registers; later changes on its inputs are ignored;
  - drive ABUS with the captured address;
  - go to LATCH if reading, WSETUP if writing.
- Tie (both REQ high):
  - P_PRIO = 1: P wins.
  - P_PRIO = 0: the requester not granted last time wins; the last-grant pointer resets to P, so C wins the first tie.
  - A lone request always wins.
- Read path:
  - LATCH: nLm = 0.
  - RD: nCE = 0; DIN is captured into RDATA at the edge that leaves RD.
  - Then ACK.
- Write path:
  - WSETUP: DOE = 1, nWE = 1.
  - WR: DOE = 1, nWE = 0.
  - WHOLD: DOE = 1, nWE = 1.
  - Then ACK.
  - ABUS and DOUT stay stable across WSETUP, WR and WHOLD.
- ACK: the granted port's DONE = 1 for one cycle, then unconditional return to IDLE; GNT clears on leaving ACK.
- nLm, nCE and nWE are mutually exclusive; at most one is low in any cycle. DOE = 1 only in WSETUP, WR and WHOLD.
- Requester handshake: drop REQ at the edge ending the DONE cycle. A REQ still high in the following IDLE cycle counts as a new request.

## Timing
- Reset values (async, while nRST = 0):
  - state IDLE;
  - nLm = nCE = nWE = 1;
  - DOE = 0; ABUS = 0; DOUT = 0; RDATA = 0;
  - all GNT, DONE and BUSY = 0;
  - last-grant pointer = P.
- Reset mid-transaction: abort immediately with no DONE. A write aborted during WR leaves that RAM word undefined.
- Read latency: REQ sampled at edge 0 → LATCH in cycle 1 → RD in cycle 2 → DONE and valid RDATA in cycle 3. Minimum period from IDLE back to IDLE is 4 cycles.
- Write latency: REQ sampled at edge 0 → DONE in cycle 4. Minimum period is 5 cycles.
- The losing requester waits, with its REQ held, until the next IDLE sample. With P_PRIO = 0, neither port waits more than one transaction.
- The RAM's write path is level-sensitive. The WSETUP/WHOLD guard cycles keep address and data stable on both sides of the nWE low pulse.

## Structure
- Package mem_arb_pkg holds:
  - the state enum (3-bit encoding);
  - the AW/DW defaults;
  - the port index constants PORT_C = 0 and PORT_P = 1.
- Sub-module mem_arb_rr: combinational two-input winner select plus the registered last-grant pointer, with the P_PRIO parameter. The top level holds the FSM and capture registers.

## Test plan
- Reset mid-read: assert nRST low in cycle 2 of a C read → all strobes high, BUSY = 0, no C_DONE, state IDLE.
- P write to address 0x3 with data 0xA5, then C read of 0x3:
  - write: nWE low for exactly 1 cycle, with ABUS = 0x3 and DOUT = 0xA5 stable one cycle either side;
  - read: C_DONE 3 cycles after grant, RDATA = 0xA5.
- Both REQ high continuously, P_PRIO = 0, all reads → grants alternate C, P, C, P; each DONE arrives 4 cycles after the previous one.
- Same stimulus with P_PRIO = 1 → P granted on every transaction; C starves until P_REQ drops, then is granted at the next IDLE.
- C changes C_ADDR from 0x5 to 0x9 during LATCH → ABUS stays 0x5 and RDATA is memory[0x5].
- C holds C_REQ one cycle past C_DONE → a second read is issued, with a second C_DONE 4 cycles later.
